dmi_request_sequencer: RTL

Sequences Debug Module Interface (DMI) requests from the debug transport onto the debug module's TileLink-style DMI port (a/d channels), one transaction at a time. It translates DMI read, write and nop ops into Get and PutFullData beats, captures the d-channel reply, and returns a DMI response code. It bounds every bus transaction with a timeout and keeps a sticky error that the transport clears explicitly. It sits between the DTM and the debug module outer block.

---
 rtl/dmi_seq_pkg.sv | 37 +++
 rtl/dmi_timeout_counter.sv | 29 ++
 rtl/dmi_request_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dmi_seq_pkg.sv
// Shared types and encodings for the DMI request sequencer: DMI ops,
// response codes, TileLink opcodes and the sequencer state.
package dmi_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_OK     = 2'd0,
    RESP_FAILED = 2'd2
  } dmi_resp_e;

  localparam logic [2:0] TL_GET     = 3'd4;
  localparam logic [2:0] TL_PUTFULL = 3'd0;
  localparam logic [2:0] TL_ACK     = 3'd0;
  localparam logic [2:0] TL_ACKDATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_WAIT_D,
    ST_RESP
  } state_e;

  // The reserved encoding behaves exactly like a nop.
  function automatic dmi_op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_READ;
      2'd2:    return OP_WRITE;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/dmi_timeout_counter.sv
// Bus-transaction watchdog: counts enabled cycles since the last clear and
// flags the final permitted cycle of a transaction.
module dmi_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/dmi_request_sequencer.sv
// Sequences DMI requests onto a TileLink-style a/d port one transaction at a
// time, with a bus timeout and a sticky error cleared by the transport.
module dmi_request_sequencer
  import dmi_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmi_req_valid,
  output logic        dmi_req_ready,
  input  logic [1:0]  dmi_req_op,
  input  logic [6:0]  dmi_req_addr,
  input  logic [31:0] dmi_req_data,
  output logic        dmi_resp_valid,
  input  logic        dmi_resp_ready,
  output logic [31:0] dmi_resp_data,
  output logic [1:0]  dmi_resp_code,
  input  logic        dmi_clear_err,
  output logic        sticky_err,
  output logic        busy,
  output logic        tl_a_valid,
  input  logic        tl_a_ready,
  output logic [2:0]  tl_a_opcode,
  output logic [6:0]  tl_a_address,
  output logic [31:0] tl_a_data,
  input  logic        tl_d_valid,
  output logic        tl_d_ready,
  input  logic [2:0]  tl_d_opcode,
  input  logic [31:0] tl_d_data
);

  state_e      state_q, state_next;
  dmi_op_e     op_q, op_next;
  logic [6:0]  addr_q, addr_next;
  logic [31:0] data_q, data_next;
  logic [2:0]  a_opcode_q, a_opcode_next;
  logic [31:0] resp_data_q, resp_data_next;
  logic [1:0]  resp_code_q, resp_code_next;
  logic        err_set;
  logic        tmo_clear;
  logic        tmo_expired;
  logic        reply_fire;
  logic        reply_ok;
  dmi_op_e     req_op;

  dmi_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tl_d_ready),
    .expired (tmo_expired)
  );

  // Bus-facing strobes come from the state decode only, never from request inputs.
  assign dmi_req_ready  = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign tl_a_valid     = (state_q == ST_SEND_A);
  assign tl_d_ready     = (state_q == ST_SEND_A) || (state_q == ST_WAIT_D);
  assign dmi_resp_valid = (state_q == ST_RESP);
  assign tl_a_opcode    = a_opcode_q;
  assign tl_a_address   = addr_q;
  assign tl_a_data      = data_q;
  assign dmi_resp_data  = resp_data_q;
  assign dmi_resp_code  = resp_code_q;

  assign req_op = decode_op(dmi_req_op);

  // A d beat in SEND_A only counts as the reply when the a beat fires with it.
  assign reply_fire = tl_d_valid && tl_d_ready && ((state_q == ST_WAIT_D) || tl_a_ready);
  assign reply_ok   = ((op_q == OP_READ)  && (tl_d_opcode == TL_ACKDATA)) ||
                      ((op_q == OP_WRITE) && (tl_d_opcode == TL_ACK));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state_q;
    op_next        = op_q;
    addr_next      = addr_q;
    data_next      = data_q;
    a_opcode_next  = a_opcode_q;
    resp_data_next = resp_data_q;
    resp_code_next = resp_code_q;
    err_set        = 1'b0;
    tmo_clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid) begin
          op_next        = req_op;
          addr_next      = dmi_req_addr;
          data_next      = dmi_req_data;
          a_opcode_next  = (req_op == OP_READ) ? TL_GET : TL_PUTFULL;
          resp_data_next = '0;
          if ((req_op == OP_NOP) || sticky_err) begin
            resp_code_next = sticky_err ? RESP_FAILED : RESP_OK;
            state_next     = ST_RESP;
          end else begin
            tmo_clear  = 1'b1;
            state_next = ST_SEND_A;
          end
        end
      end
      ST_SEND_A, ST_WAIT_D: begin
        if (reply_fire) begin
          resp_code_next = reply_ok ? RESP_OK : RESP_FAILED;
          resp_data_next = (reply_ok && (op_q == OP_READ)) ? tl_d_data : '0;
          err_set        = !reply_ok;
          state_next     = ST_RESP;
        end else if (tmo_expired) begin
          resp_code_next = RESP_FAILED;
          resp_data_next = '0;
          err_set        = 1'b1;
          state_next     = ST_RESP;
        end else if ((state_q == ST_SEND_A) && tl_a_ready) begin
          state_next = ST_WAIT_D;
        end
      end
      ST_RESP: begin
        if (dmi_resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      a_opcode_q  <= '0;
      resp_data_q <= '0;
      resp_code_q <= '0;
      sticky_err  <= 1'b0;
    end else begin
      state_q     <= state_next;
      op_q        <= op_next;
      addr_q      <= addr_next;
      data_q      <= data_next;
      a_opcode_q  <= a_opcode_next;
      resp_data_q <= resp_data_next;
      resp_code_q <= resp_code_next;
      if (err_set) begin
        sticky_err <= 1'b1;
      end else if (dmi_clear_err) begin
        sticky_err <= 1'b0;
      end
    end
  end

endmodule
